// File: rtl/fp32_pkg.sv
// Shared definitions for the FP32 multiplier output stage.
// Holds the binary32 encoding constants, the exception flag bundle and the
// stage-1 payload carried between the normalise and round/encode stages.
package fp32_pkg;

    localparam logic [31:0] FP32_QNAN    = 32'h7FC0_0000;
    localparam logic [7:0]  FP32_EXP_INF = 8'hFF;
    localparam logic [9:0]  FP32_BIAS    = 10'd127;

    // IEEE-754 exception flags produced with each result
    typedef struct packed {
        logic nv;
        logic of;
        logic uf;
        logic nx;
    } fp32_flags_t;

    // Normalised significand plus rounding bits, waiting to be rounded
    typedef struct packed {
        logic        sign;
        logic [9:0]  e;       // two's complement, biased exponent
        logic [22:0] m;       // fraction without hidden bit
        logic        g;       // guard bit
        logic        s;       // sticky bit
        logic        lsb;     // fraction LSB, breaks round-to-even ties
        logic        is_nan;
        logic        is_inf;
        logic        is_zero;
    } fp32_s1_t;

endpackage

// File: rtl/fp32_round_rne.sv
// Round-to-nearest-even on a normalised 23-bit fraction.
// Ports:
//   i_m, i_g, i_s, i_lsb : fraction, guard, sticky, fraction LSB
//   i_e                  : signed 10-bit biased exponent
//   o_m, o_e             : rounded fraction and exponent (bumped on carry-out)
//   o_of, o_uf, o_nx     : exponent >= 255, exponent <= 0, inexact
module fp32_round_rne
    import fp32_pkg::*;
(
    input  logic [22:0] i_m,
    input  logic        i_g,
    input  logic        i_s,
    input  logic        i_lsb,
    input  logic [9:0]  i_e,
    output logic [22:0] o_m,
    output logic [9:0]  o_e,
    output logic        o_of,
    output logic        o_uf,
    output logic        o_nx
);

    logic        w_up;
    logic [23:0] w_sum;

    // Round increment and exponent adjustment on fraction carry-out
    always_comb begin
        w_up  = i_g & (i_s | i_lsb);
        w_sum = {1'b0, i_m} + {23'd0, w_up};
        if (w_sum[23]) begin
            // 1.111..1 + ulp = 10.000..0: fraction wraps to zero, exponent steps up
            o_m = 23'd0;
            o_e = i_e + 10'd1;
        end else begin
            o_m = w_sum[22:0];
            o_e = i_e;
        end
        o_of = ($signed(o_e) >= $signed(10'd255));
        o_uf = ($signed(o_e) <= $signed(10'd0));
        o_nx = i_g | i_s;
    end

endmodule

// File: rtl/fp32_mul_packer.sv
// FP32 multiplier output stage: normalise, round to nearest-even, encode
// special values and pack a binary32 result with exception flags.
// Two-stage pipeline, valid/ready on both sides, latency 2, throughput 1.
// Ports:
//   i_clk, i_rst_n                 : clock, async active-low reset
//   i_valid / o_ready              : upstream handshake
//   i_sign, i_exp_sum, i_mant_prod : raw product (exp signed 10-bit, prod 2.46)
//   i_is_nan, i_is_inf, i_is_zero  : operand class flags
//   o_valid / i_ready              : downstream handshake
//   o_result                       : packed binary32
//   o_flag_nv/of/uf/nx             : invalid, overflow, underflow, inexact
module fp32_mul_packer
    import fp32_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_sign,
    input  logic [9:0]  i_exp_sum,
    input  logic [47:0] i_mant_prod,
    input  logic        i_is_nan,
    input  logic        i_is_inf,
    input  logic        i_is_zero,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_result,
    output logic        o_flag_nv,
    output logic        o_flag_of,
    output logic        o_flag_uf,
    output logic        o_flag_nx
);

    logic        r_v1;
    logic        r_v2;
    fp32_s1_t    r_s1;
    fp32_s1_t    w_s1_next;
    logic        w_ready_s2;
    logic [31:0] r_result;
    fp32_flags_t r_flags;
    logic [31:0] w_result;
    fp32_flags_t w_flags;
    logic        w_nan;
    logic [22:0] w_rnd_m;
    logic [9:0]  w_rnd_e;
    logic        w_rnd_of;
    logic        w_rnd_uf;
    logic        w_rnd_nx;

    // Each stage advances when empty or when the stage after it drains
    assign w_ready_s2 = ~r_v2 | i_ready;
    assign o_ready    = ~r_v1 | w_ready_s2;
    assign o_valid    = r_v2;
    assign o_result   = r_result;
    assign o_flag_nv  = r_flags.nv;
    assign o_flag_of  = r_flags.of;
    assign o_flag_uf  = r_flags.uf;
    assign o_flag_nx  = r_flags.nx;

    // Stage 1 normalise: a product in [2,4) shifts right by one and bumps e
    always_comb begin
        w_s1_next.sign    = i_sign;
        w_s1_next.is_nan  = i_is_nan;
        w_s1_next.is_inf  = i_is_inf;
        w_s1_next.is_zero = i_is_zero;
        if (i_mant_prod[47]) begin
            w_s1_next.m   = i_mant_prod[46:24];
            w_s1_next.g   = i_mant_prod[23];
            w_s1_next.s   = |i_mant_prod[22:0];
            w_s1_next.lsb = i_mant_prod[24];
            w_s1_next.e   = i_exp_sum + 10'd1;
        end else begin
            w_s1_next.m   = i_mant_prod[45:23];
            w_s1_next.g   = i_mant_prod[22];
            w_s1_next.s   = |i_mant_prod[21:0];
            w_s1_next.lsb = i_mant_prod[23];
            w_s1_next.e   = i_exp_sum;
        end
    end

    // Stage 1 register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_v1 <= 1'b0;
            r_s1 <= '0;
        end else if (o_ready) begin
            r_v1 <= i_valid;
            if (i_valid) begin
                r_s1 <= w_s1_next;
            end
        end
    end

    fp32_round_rne u_round (
        .i_m   (r_s1.m),
        .i_g   (r_s1.g),
        .i_s   (r_s1.s),
        .i_lsb (r_s1.lsb),
        .i_e   (r_s1.e),
        .o_m   (w_rnd_m),
        .o_e   (w_rnd_e),
        .o_of  (w_rnd_of),
        .o_uf  (w_rnd_uf),
        .o_nx  (w_rnd_nx)
    );

    // Stage 2 encode: NaN beats Inf beats Zero beats the rounded number
    always_comb begin
        w_nan    = r_s1.is_nan | (r_s1.is_inf & r_s1.is_zero);
        w_result = 32'd0;
        w_flags  = '0;
        if (w_nan) begin
            w_result   = FP32_QNAN;
            // Only Inf*0 is an invalid operation; a NaN operand propagates quietly
            w_flags.nv = ~r_s1.is_nan & r_s1.is_inf & r_s1.is_zero;
        end else if (r_s1.is_inf) begin
            w_result = {r_s1.sign, FP32_EXP_INF, 23'd0};
        end else if (r_s1.is_zero) begin
            w_result = {r_s1.sign, 31'd0};
        end else if (w_rnd_of) begin
            w_result   = {r_s1.sign, FP32_EXP_INF, 23'd0};
            w_flags.of = 1'b1;
            w_flags.nx = 1'b1;
        end else if (w_rnd_uf) begin
            // No subnormals: tiny results flush to signed zero
            w_result   = {r_s1.sign, 31'd0};
            w_flags.uf = 1'b1;
            w_flags.nx = 1'b1;
        end else begin
            w_result   = {r_s1.sign, w_rnd_e[7:0], w_rnd_m};
            w_flags.nx = w_rnd_nx;
        end
    end

    // Stage 2 register; result and flags hold while downstream stalls
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_v2     <= 1'b0;
            r_result <= 32'd0;
            r_flags  <= '0;
        end else if (w_ready_s2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_result <= w_result;
                r_flags  <= w_flags;
            end
        end
    end

endmodule

// File: tb/tb_fp32_mul_packer.sv
module tb_fp32_mul_packer;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic        i_sign;
    logic [9:0]  i_exp_sum;
    logic [47:0] i_mant_prod;
    logic        i_is_nan;
    logic        i_is_inf;
    logic        i_is_zero;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;
    logic        o_flag_nv;
    logic        o_flag_of;
    logic        o_flag_uf;
    logic        o_flag_nx;

    int errors = 0;
    int checks = 0;

    fp32_mul_packer dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_sign      (i_sign),
        .i_exp_sum   (i_exp_sum),
        .i_mant_prod (i_mant_prod),
        .i_is_nan    (i_is_nan),
        .i_is_inf    (i_is_inf),
        .i_is_zero   (i_is_zero),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_result    (o_result),
        .o_flag_nv   (o_flag_nv),
        .o_flag_of   (o_flag_of),
        .o_flag_uf   (o_flag_uf),
        .o_flag_nx   (o_flag_nx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] flags_now();
        return {28'd0, o_flag_nv, o_flag_of, o_flag_uf, o_flag_nx};
    endfunction

    task automatic drive(input logic s, input logic [9:0] e, input logic [47:0] p,
                         input logic nan, input logic inf, input logic zero);
        i_valid     = 1'b1;
        i_sign      = s;
        i_exp_sum   = e;
        i_mant_prod = p;
        i_is_nan    = nan;
        i_is_inf    = inf;
        i_is_zero   = zero;
    endtask

    // One item through an unstalled pipe; result checked two edges later
    task automatic run_one(input string tag, input logic s, input logic [9:0] e,
                           input logic [47:0] p, input logic nan, input logic inf,
                           input logic zero, input logic [31:0] exp_res,
                           input logic [3:0] exp_flags);
        @(negedge clk);
        drive(s, e, p, nan, inf, zero);
        i_ready = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        @(negedge clk);
        check({tag, "_valid"}, {31'd0, o_valid}, 32'd1);
        check({tag, "_res"}, o_result, exp_res);
        check({tag, "_flags"}, flags_now(), {28'd0, exp_flags});
    endtask

    logic [31:0] bp_exp [4];
    logic [31:0] held;
    logic        stalled_prev;
    logic        saw_not_ready;
    logic        acc_in;
    int          tx;
    int          rx;
    int          stall;
    logic        seen;

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 10'd0, 48'd0, 1'b0, 1'b0, 1'b0);
        i_valid = 1'b0;
        i_ready = 1'b1;
        #12;
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_result", o_result, 32'd0);
        check("rst_flags", flags_now(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_ready", {31'd0, o_ready}, 32'd1);

        // flags order {nv, of, uf, nx}
        run_one("mul_1p5x2", 1'b0, 10'd128, 48'h6000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h4040_0000, 4'b0000);
        run_one("rnd_carry", 1'b0, 10'd127, 48'h7FFF_FFC0_0000, 1'b0, 1'b0, 1'b0, 32'h4000_0000, 4'b0001);
        run_one("rnd_noup",  1'b0, 10'd127, 48'h4000_0080_0001, 1'b0, 1'b0, 1'b0, 32'h3F80_0001, 4'b0001);
        run_one("tie_even",  1'b0, 10'd127, 48'h4000_0040_0000, 1'b0, 1'b0, 1'b0, 32'h3F80_0000, 4'b0001);
        run_one("ovf_pos",   1'b0, 10'd254, 48'h8000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h7F80_0000, 4'b0101);
        run_one("ovf_neg",   1'b1, 10'd254, 48'h8000_0000_0000, 1'b0, 1'b0, 1'b0, 32'hFF80_0000, 4'b0101);
        run_one("unf_neg",   1'b1, 10'd0,   48'h4000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 4'b0011);
        run_one("inf_x0",    1'b0, 10'd0,   48'h0,              1'b0, 1'b1, 1'b1, 32'h7FC0_0000, 4'b1000);
        run_one("nan_op",    1'b1, 10'd5,   48'h4000_0000_0000, 1'b1, 1'b0, 1'b0, 32'h7FC0_0000, 4'b0000);
        run_one("inf_neg",   1'b1, 10'd5,   48'h4000_0000_0000, 1'b0, 1'b1, 1'b0, 32'hFF80_0000, 4'b0000);
        run_one("zero_neg",  1'b1, 10'd130, 48'h4000_0000_0000, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 4'b0000);

        // Backpressure: 4 back-to-back items, downstream stalls 3 cycles at first o_valid
        bp_exp[0] = 32'h3F80_0000;
        bp_exp[1] = 32'h4000_0000;
        bp_exp[2] = 32'h4080_0000;
        bp_exp[3] = 32'h4100_0000;
        tx = 0; rx = 0; stall = 0; seen = 1'b0;
        stalled_prev = 1'b0; saw_not_ready = 1'b0; held = 32'd0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (stalled_prev) begin
                check("bp_hold_valid", {31'd0, o_valid}, 32'd1);
                check("bp_hold_res", o_result, held);
            end
            if (o_valid && !seen) begin
                seen  = 1'b1;
                stall = 3;
            end
            i_ready = (stall == 0);
            if (stall > 0) stall--;
            if (tx < 4) drive(1'b0, 10'(127 + tx), 48'h4000_0000_0000, 1'b0, 1'b0, 1'b0);
            else i_valid = 1'b0;
            #1;
            if (!o_ready) saw_not_ready = 1'b1;
            acc_in = i_valid & o_ready;
            if (o_valid && i_ready) begin
                if (rx < 4) check("bp_order", o_result, bp_exp[rx]);
                else check("bp_extra", 32'd1, 32'd0);
                rx++;
            end
            stalled_prev = o_valid & ~i_ready;
            held = o_result;
            @(posedge clk);
            if (acc_in) tx++;
        end
        check("bp_count", rx, 32'd4);
        check("bp_ready_fell", {31'd0, saw_not_ready}, 32'd1);
        check("bp_drained", {31'd0, o_valid}, 32'd0);

        // Reset while both stages hold items
        @(negedge clk);
        i_ready = 1'b0;
        drive(1'b0, 10'd127, 48'h4000_0000_0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 10'd128, 48'h4000_0000_0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        i_valid = 1'b0;
        check("mid_inflight", {31'd0, o_valid}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, o_valid}, 32'd0);
        check("mid_rst_result", o_result, 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        i_ready = 1'b1;
        #1;
        check("mid_rst_ready", {31'd0, o_ready}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("mid_no_replay", {31'd0, o_valid}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
